// File: rtl/cc_fill_ctrl.sv
// rtl/cc_fill_ctrl.sv - instruction cache refill engine
// Filters a miss against the cache, fetches eight beats, writes the line, reports evictions.
module cc_fill_ctrl #(
  parameter int IP_WIDTH   = 44,
  parameter int BEAT_WIDTH = 130,
  parameter int BEATS      = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             miss_en,
  input  logic [IP_WIDTH-6:0]              miss_IP,
  output logic                             miss_busy,
  input  logic                             flush,
  output logic [IP_WIDTH-6:0]              chkCL_IP,
  output logic                             chkCL_clkEn,
  input  logic                             chkCL_hit,
  output logic                             req_en,
  output logic [IP_WIDTH-6:0]              req_addr,
  input  logic                             req_ack,
  input  logic                             rsp_en,
  input  logic [BEAT_WIDTH-1:0]            rsp_data,
  input  logic                             rsp_err,
  output logic [IP_WIDTH-6:0]              write_IP,
  output logic [BEAT_WIDTH*BEATS-1:0]      write_data,
  output logic                             write_wen,
  input  logic                             expun_hit,
  input  logic [IP_WIDTH-8:0]              expun_addr,
  output logic                             expun_en,
  output logic [IP_WIDTH-8:0]              expun_addr_out,
  output logic                             fill_done,
  output logic [1:0]                       fill_status
);

  localparam int LA_W  = IP_WIDTH - 5;
  localparam int EA_W  = IP_WIDTH - 7;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [1:0] ST_WRITTEN = 2'd0;
  localparam logic [1:0] ST_PRESENT = 2'd1;
  localparam logic [1:0] ST_BUSERR  = 2'd2;
  localparam logic [1:0] ST_FLUSHED = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_COLLECT,
    S_WRITE,
    S_EXPUN
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LA_W-1:0]  line_reg;
  logic [CNT_W-1:0] cnt;
  logic             err_flag;
  logic             abort_flag;
  logic [EA_W-1:0]  expun_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      line_reg   <= '0;
      cnt        <= '0;
      err_flag   <= 1'b0;
      abort_flag <= 1'b0;
      write_data <= '0;
      expun_reg  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && miss_en) begin
        line_reg <= miss_IP;
      end
      // A flush in the ack cycle cannot cancel the bus, so it becomes a drain-and-abort.
      if (state == S_REQ && req_ack) begin
        cnt        <= '0;
        err_flag   <= 1'b0;
        abort_flag <= flush;
      end
      if (state == S_COLLECT) begin
        if (flush) begin
          abort_flag <= 1'b1;
        end
        if (rsp_en) begin
          for (int k = 0; k < BEATS; k++) begin
            if (cnt == CNT_W'(k)) begin
              write_data[k*BEAT_WIDTH +: BEAT_WIDTH] <= rsp_data;
            end
          end
          cnt <= cnt + CNT_W'(1);
          if (rsp_err) begin
            err_flag <= 1'b1;
          end
        end
      end
      if (expun_en) begin
        expun_reg <= expun_addr;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    chkCL_clkEn = 1'b0;
    chkCL_IP    = '0;
    req_en      = 1'b0;
    req_addr    = '0;
    write_wen   = 1'b0;
    write_IP    = '0;
    expun_en    = 1'b0;
    fill_done   = 1'b0;
    fill_status = ST_WRITTEN;
    case (state)
      S_IDLE: begin
        if (miss_en) begin
          chkCL_clkEn = 1'b1;
          chkCL_IP    = miss_IP;
          state_nxt   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (flush) begin
          fill_done   = 1'b1;
          fill_status = ST_FLUSHED;
          state_nxt   = S_IDLE;
        end else if (chkCL_hit) begin
          fill_done   = 1'b1;
          fill_status = ST_PRESENT;
          state_nxt   = S_IDLE;
        end else begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        req_en   = 1'b1;
        req_addr = line_reg;
        if (req_ack) begin
          state_nxt = S_COLLECT;
        end else if (flush) begin
          fill_done   = 1'b1;
          fill_status = ST_FLUSHED;
          state_nxt   = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (rsp_en && cnt == LAST_BEAT) begin
          if (abort_flag || flush) begin
            fill_done   = 1'b1;
            fill_status = ST_FLUSHED;
            state_nxt   = S_IDLE;
          end else if (err_flag || rsp_err) begin
            fill_done   = 1'b1;
            fill_status = ST_BUSERR;
            state_nxt   = S_IDLE;
          end else begin
            state_nxt = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        write_wen = 1'b1;
        write_IP  = line_reg;
        state_nxt = S_EXPUN;
      end
      S_EXPUN: begin
        expun_en    = expun_hit;
        fill_done   = 1'b1;
        fill_status = ST_WRITTEN;
        state_nxt   = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign miss_busy = (state != S_IDLE);

  // Bypass so the new address is visible alongside the expun_en pulse, then held.
  assign expun_addr_out = expun_en ? expun_addr : expun_reg;

endmodule

// File: tb/tb_cc_fill_ctrl.sv
// tb/tb_cc_fill_ctrl.sv - self-checking bench for cc_fill_ctrl
// Cycle-accurate expectations are derived per transaction from timing rules, not from the RTL.
module tb_cc_fill_ctrl;

  localparam int LA = 39;
  localparam int EA = 37;
  localparam int BW = 130;
  localparam int LW = 1040;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_en;
  logic [LA-1:0] miss_IP;
  logic          miss_busy;
  logic          flush;
  logic [LA-1:0] chkCL_IP;
  logic          chkCL_clkEn;
  logic          chkCL_hit;
  logic          req_en;
  logic [LA-1:0] req_addr;
  logic          req_ack;
  logic          rsp_en;
  logic [BW-1:0] rsp_data;
  logic          rsp_err;
  logic [LA-1:0] write_IP;
  logic [LW-1:0] write_data;
  logic          write_wen;
  logic          expun_hit;
  logic [EA-1:0] expun_addr;
  logic          expun_en;
  logic [EA-1:0] expun_addr_out;
  logic          fill_done;
  logic [1:0]    fill_status;

  cc_fill_ctrl dut (
    .clk(clk), .rst(rst), .miss_en(miss_en), .miss_IP(miss_IP), .miss_busy(miss_busy),
    .flush(flush), .chkCL_IP(chkCL_IP), .chkCL_clkEn(chkCL_clkEn), .chkCL_hit(chkCL_hit),
    .req_en(req_en), .req_addr(req_addr), .req_ack(req_ack), .rsp_en(rsp_en),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .write_IP(write_IP), .write_data(write_data),
    .write_wen(write_wen), .expun_hit(expun_hit), .expun_addr(expun_addr), .expun_en(expun_en),
    .expun_addr_out(expun_addr_out), .fill_done(fill_done), .fill_status(fill_status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  bit go = 1'b0;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [BW-1:0] beat_of(input int tag, input int k);
    logic [BW-1:0] b;
    b = (BW'(tag) << 64) | BW'(k);
    return b;
  endfunction

  function automatic logic [LW-1:0] line_of(input int tag);
    logic [LW-1:0] l;
    for (int k = 0; k < 8; k++) l[k*BW +: BW] = beat_of(tag, k);
    return l;
  endfunction

  // current transaction, relative-cycle description
  bit            t_act = 1'b0;
  int            t0, t_ackd, t_frel, t_errb, t_tag;
  bit            t_hit, t_ev;
  logic [LA-1:0] t_ip;
  logic [EA-1:0] t_evaddr;
  logic [LW-1:0] exp_line = '0;
  logic [EA-1:0] exp_ev = '0;

  int         n_wen, n_done, n_req, wen_at, done_at;
  logic [1:0] st_at;

  always @(negedge clk) begin : cmp
    int c, a, last, f, done_c, st, rq_hi, wen_c, ev_c;
    bit collected, e_req, e_wen, e_done;
    if (!rst && go) begin
      c = cyc; a = -100; last = -100; done_c = -100; rq_hi = -100;
      wen_c = -100; ev_c = -100; st = 0; collected = 1'b0;
      if (t_act) begin
        f = (t_frel >= 0) ? t0 + t_frel : -100;
        a = t0 + 2 + t_ackd;
        last = a + 8;
        if (f == t0 + 1) begin done_c = t0 + 1; st = 3; end
        else if (t_hit) begin done_c = t0 + 1; st = 1; end
        else if (f >= t0 + 2 && f < a) begin rq_hi = f; done_c = f; st = 3; end
        else begin
          rq_hi = a; collected = 1'b1;
          if (f >= a && f <= last) begin done_c = last; st = 3; end
          else if (t_errb >= 0) begin done_c = last; st = 2; end
          else begin
            wen_c = last + 1; done_c = last + 2; st = 0;
            if (t_ev) ev_c = last + 2;
          end
        end
      end
      if (c == ev_c) exp_ev = t_evaddr;
      if (collected && c == last + 1) exp_line = line_of(t_tag);
      e_req  = t_act && c >= t0 + 2 && c <= rq_hi;
      e_wen  = (c == wen_c);
      e_done = (c == done_c);
      chk("miss_busy", miss_busy, t_act && c > t0 && c <= done_c);
      chk("chkCL_clkEn", chkCL_clkEn, t_act && c == t0);
      chk("chkCL_IP", chkCL_IP, (t_act && c == t0) ? t_ip : '0);
      chk("req_en", req_en, e_req);
      chk("req_addr", req_addr, e_req ? t_ip : '0);
      chk("write_wen", write_wen, e_wen);
      chk("write_IP", write_IP, e_wen ? t_ip : '0);
      chk("fill_done", fill_done, e_done);
      chk("fill_status", fill_status, e_done ? 2'(st) : 2'd0);
      chk("expun_en", expun_en, c == ev_c);
      chk("expun_addr_out", expun_addr_out, exp_ev);
      if (!(collected && c > a + 1 && c <= last)) chk("write_data", write_data, exp_line);
      if (write_wen) begin n_wen++; wen_at = c; end
      if (fill_done) begin n_done++; done_at = c; st_at = fill_status; end
      if (req_en) n_req++;
    end
  end

  task automatic zero_inputs();
    miss_en = 0; miss_IP = '0; flush = 0; chkCL_hit = 0; req_ack = 0;
    rsp_en = 0; rsp_data = '0; rsp_err = 0; expun_hit = 0; expun_addr = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, miss_busy, 0);
    chk({tag, "_chken"}, chkCL_clkEn, 0);
    chk({tag, "_chkip"}, chkCL_IP, 0);
    chk({tag, "_req"}, req_en, 0);
    chk({tag, "_reqaddr"}, req_addr, 0);
    chk({tag, "_wen"}, write_wen, 0);
    chk({tag, "_wdata"}, write_data, 0);
    chk({tag, "_done"}, fill_done, 0);
    chk({tag, "_status"}, fill_status, 0);
    chk({tag, "_expun"}, expun_en, 0);
    chk({tag, "_expaddr"}, expun_addr_out, 0);
  endtask

  task automatic run(input logic [LA-1:0] ip, input int tag, input bit hit, input int ackd,
                     input int frel, input int errb, input bit ev, input logic [EA-1:0] evaddr,
                     input int xrel, input int rst_rel);
    int k;
    n_wen = 0; n_done = 0; n_req = 0; wen_at = -1; done_at = -1; st_at = 0;
    @(posedge clk); #1;
    t0 = cyc; t_ip = ip; t_tag = tag; t_hit = hit; t_ackd = ackd; t_frel = frel;
    t_errb = errb; t_ev = ev; t_evaddr = evaddr; t_act = 1'b1;
    for (int r = 0; r < ackd + 16; r++) begin
      if (r > 0) begin @(posedge clk); #1; end
      if (r == rst_rel) begin
        #2 rst = 1'b1;
        t_act = 1'b0; exp_line = '0; exp_ev = '0;
        #1 check_all_zero("async_rst");
        zero_inputs();
        @(negedge clk); #2 rst = 1'b0;
        break;
      end
      miss_en   = (r == 0) || (r == xrel);
      miss_IP   = (r == 0) ? ip : ~ip;
      chkCL_hit = (r == 1) ? hit : 1'b0;
      req_ack   = (r == 2 + ackd);
      k         = r - (3 + ackd);
      rsp_en    = (k >= 0 && k < 8);
      rsp_data  = (k >= 0 && k < 8) ? beat_of(tag, k) : '0;
      rsp_err   = (k == errb) && (k >= 0);
      flush     = (r == frel);
      expun_hit = ev && (r == 12 + ackd);
      expun_addr = evaddr;
    end
    zero_inputs();
  endtask

  initial begin
    zero_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst = 1'b0;
    go = 1'b1;
    repeat (2) @(posedge clk);

    // clean fill, beats carry k only
    run(39'h12_3456_789A, 0, 0, 0, -1, -1, 0, 37'h0_1234_5678, -1, -1);
    chk("clean_wen_cycle", wen_at - t0, 11);
    chk("clean_done_cycle", done_at - t0, 12);
    chk("clean_status", st_at, 0);
    chk("clean_beat5", write_data[5*BW +: BW], 130'd5);
    chk("clean_one_write", n_wen, 1);

    // duplicate, with a miss in the fill_done cycle that must be ignored
    run(39'h00_0000_1111, 1, 1, 0, -1, -1, 0, 37'h0, 1, -1);
    chk("dup_done_cycle", done_at - t0, 1);
    chk("dup_status", st_at, 1);
    chk("dup_no_req", n_req, 0);
    chk("dup_one_done", n_done, 1);

    // eviction reported after the write
    run(39'h7F_0000_2222, 2, 0, 0, -1, -1, 1, 37'h1F_0000_0ABC, -1, -1);
    chk("evict_addr", expun_addr_out, 37'h1F_0000_0ABC);
    chk("evict_status", st_at, 0);

    // bus error on beat 3
    run(39'h01_0000_3333, 3, 0, 1, -1, 3, 1, 37'h0_0000_0777, -1, -1);
    chk("err_status", st_at, 2);
    chk("err_no_write", n_wen, 0);

    // flush during beat 5
    run(39'h02_0000_4444, 4, 0, 0, 8, -1, 0, 37'h0, -1, -1);
    chk("flush5_status", st_at, 3);
    chk("flush5_no_write", n_wen, 0);
    chk("flush5_done_cycle", done_at - t0, 10);

    // backpressure: ack after 20 stalled cycles, second miss while busy
    run(39'h03_0000_5555, 5, 0, 20, -1, -1, 0, 37'h0, 5, -1);
    chk("bp_one_done", n_done, 1);
    chk("bp_req_cycles", n_req, 21);
    chk("bp_wen_cycle", wen_at - t0, 31);

    // flush in CHECK, flush in REQ before ack, flush in ack cycle, flush during WRITE
    run(39'h04_0000_6666, 6, 0, 0, 1, -1, 0, 37'h0, -1, -1);
    chk("flush_check_status", st_at, 3);
    run(39'h05_0000_7777, 8, 0, 4, 3, -1, 0, 37'h0, -1, -1);
    chk("flush_req_done_cycle", done_at - t0, 3);
    run(39'h06_0000_8888, 9, 0, 2, 4, -1, 0, 37'h0, -1, -1);
    chk("flush_ack_status", st_at, 3);
    run(39'h07_0000_9999, 10, 0, 0, 11, -1, 1, 37'h0_0000_0042, -1, -1);
    chk("flush_write_status", st_at, 0);

    // async reset after beat 4, then a fresh fill
    run(39'h08_0000_AAAA, 11, 0, 0, -1, -1, 0, 37'h0, -1, 8);
    repeat (2) @(posedge clk);
    run(39'h09_0000_BBBB, 7, 0, 0, -1, -1, 0, 37'h0, -1, -1);
    chk("post_rst_wen_cycle", wen_at - t0, 11);
    chk("post_rst_beat0", write_data[0 +: BW], beat_of(7, 0));
    chk("post_rst_beat7", write_data[7*BW +: BW], beat_of(7, 7));

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
